// File: rtl/pipes_pkg.sv
// Types and constants shared by the pipeline stages: the fetch-to-decode
// payload, the fetch FSM states and the default reset PC.
package pipes_pkg;

  localparam logic [63:0] PCINIT_DEFAULT = 64'h8000_0000;

  typedef struct packed {
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        is_bubble;
  } fetch_data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one request at a time on the instruction bus,
// buffers a word across decode stalls, and handles decode/execute redirects.
module fetch_stage
  import pipes_pkg::*;
#(
  parameter logic [63:0] PCINIT = PCINIT_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  output logic         ireq_valid,
  output logic [63:0]  ireq_addr,
  input  logic         iresp_data_ok,
  input  logic [31:0]  iresp_data,
  input  logic         stall,
  input  logic         is_jump,
  input  logic [63:0]  offset,
  input  logic         ex_redirect,
  input  logic [63:0]  ex_target,
  output fetch_data_t  dataF,
  output fetch_state_t state_dbg
);

  // Bus handshake: ireq_valid high means a request for ireq_addr is outstanding;
  // the address is held until iresp_data_ok completes it. A redirect never
  // cancels an issued request -- its data is dropped when it arrives.

  fetch_state_t state, state_n;
  logic [63:0]  pc, pc_n;
  logic [63:0]  saved_target, saved_target_n;
  logic [31:0]  buffer, buffer_n;
  fetch_data_t  dataF_n;
  logic         redir;
  logic [63:0]  target;
  logic         load;
  logic [31:0]  load_word;

  assign redir  = ex_redirect | (is_jump & ~stall & ~dataF.is_bubble);
  assign target = ex_redirect ? ex_target : (dataF.pc + offset);

  assign ireq_valid = (state == WAIT) || (state == DISCARD);
  assign ireq_addr  = pc;
  assign state_dbg  = state;

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    saved_target_n = saved_target;
    buffer_n       = buffer;
    load           = 1'b0;
    load_word      = 32'd0;
    unique case (state)
      IDLE: state_n = WAIT;
      WAIT: begin
        if (iresp_data_ok) begin
          if (redir) begin
            pc_n = target;
          end else if (stall) begin
            buffer_n = iresp_data;
            state_n  = HOLD;
          end else begin
            load      = 1'b1;
            load_word = iresp_data;
            pc_n      = pc + 64'd4;
          end
        end else if (redir) begin
          saved_target_n = target;
          state_n        = DISCARD;
        end
      end
      HOLD: begin
        if (redir) begin
          pc_n    = target;
          state_n = WAIT;
        end else if (!stall) begin
          load      = 1'b1;
          load_word = buffer;
          pc_n      = pc + 64'd4;
          state_n   = WAIT;
        end
      end
      DISCARD: begin
        // The stale response still has to drain before the new address goes out.
        if (iresp_data_ok) begin
          pc_n    = redir ? target : saved_target;
          state_n = WAIT;
        end else if (redir) begin
          saved_target_n = target;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dataF_n = dataF;
    if (load) begin
      dataF_n = '{raw_instr: load_word, pc: pc, is_bubble: 1'b0};
    end else if (!stall || ex_redirect) begin
      dataF_n.is_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      pc           <= PCINIT;
      saved_target <= 64'd0;
      buffer       <= 32'd0;
      dataF        <= '{raw_instr: 32'd0, pc: 64'd0, is_bubble: 1'b1};
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      saved_target <= saved_target_n;
      buffer       <= buffer_n;
      dataF        <= dataF_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized run checked
// against a program-order model of the instruction stream seen by decode.
module tb_fetch_stage;
  import pipes_pkg::*;

  localparam logic [63:0] PC0 = 64'h8000_0000;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ireq_valid;
  logic [63:0]  ireq_addr;
  logic         iresp_data_ok;
  logic [31:0]  iresp_data;
  logic         stall;
  logic         is_jump;
  logic [63:0]  offset;
  logic         ex_redirect;
  logic [63:0]  ex_target;
  fetch_data_t  dataF;
  fetch_state_t state_dbg;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  logic [63:0] exp_q[$];

  fetch_stage #(.PCINIT(PC0)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stall         (stall),
    .is_jump       (is_jump),
    .offset        (offset),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .dataF         (dataF),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  // instruction memory model answering the outstanding address
  assign iresp_data = iresp_data_ok ? mem_word(ireq_addr) : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic ok, input logic st, input logic jmp,
                            input logic [63:0] off, input logic exr, input logic [63:0] ext);
    iresp_data_ok = ok;
    stall         = st;
    is_jump       = jmp;
    offset        = off;
    ex_redirect   = exr;
    ex_target     = ext;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    fetch_data_t pre;
    logic        pre_valid;
    logic [63:0] pre_addr;
    logic [63:0] nxt;
    logic        take;

    resetn = 1'b0;
    set_inputs(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    @(negedge clk);
    step();

    // reset values and in-order streaming with data_ok every cycle
    check("rst_valid", 64'(ireq_valid), 64'd0);
    check("rst_addr", ireq_addr, PC0);
    check("rst_bubble", 64'(dataF.is_bubble), 64'd1);
    check("rst_state", 64'(state_dbg), 64'(IDLE));
    resetn = 1'b1;
    step();
    check("rel_state", 64'(state_dbg), 64'(WAIT));
    check("rel_addr", ireq_addr, PC0);
    check("rel_valid", 64'(ireq_valid), 64'd1);
    check("rel_bubble", 64'(dataF.is_bubble), 64'd1);
    step();
    check("s1_addr", ireq_addr, PC0 + 64'h4);
    check("s1_pc", dataF.pc, PC0);
    check("s1_raw", 64'(dataF.raw_instr), 64'(mem_word(PC0)));
    check("s1_bubble", 64'(dataF.is_bubble), 64'd0);
    step();
    check("s2_addr", ireq_addr, PC0 + 64'h8);
    check("s2_pc", dataF.pc, PC0 + 64'h4);
    check("s2_bubble", 64'(dataF.is_bubble), 64'd0);

    // stall while the response for 0x8 arrives: buffered, then delivered once
    stall = 1'b1;
    step();
    check("st_state", 64'(state_dbg), 64'(HOLD));
    check("st_hold_pc", dataF.pc, PC0 + 64'h4);
    check("st_valid", 64'(ireq_valid), 64'd0);
    iresp_data_ok = 1'b0;
    step();
    step();
    check("st3_state", 64'(state_dbg), 64'(HOLD));
    check("st3_hold_pc", dataF.pc, PC0 + 64'h4);
    check("st3_bubble", 64'(dataF.is_bubble), 64'd0);
    stall = 1'b0;
    step();
    check("unst_pc", dataF.pc, PC0 + 64'h8);
    check("unst_raw", 64'(dataF.raw_instr), 64'(mem_word(PC0 + 64'h8)));
    check("unst_state", 64'(state_dbg), 64'(WAIT));
    check("unst_addr", ireq_addr, PC0 + 64'hC);
    iresp_data_ok = 1'b1;
    step();
    check("nodup_pc", dataF.pc, PC0 + 64'hC);
    step();
    check("pre_br_pc", dataF.pc, PC0 + 64'h10);

    // decode branch at 0x10 with offset -8
    is_jump = 1'b1;
    offset  = -64'sd8;
    step();
    check("br_addr", ireq_addr, PC0 + 64'h8);
    check("br_bubble", 64'(dataF.is_bubble), 64'd1);
    is_jump = 1'b0;
    step();
    check("br_tgt_pc", dataF.pc, PC0 + 64'h8);
    check("br_tgt_bubble", 64'(dataF.is_bubble), 64'd0);

    // slow bus, then a branch: request in flight must drain in DISCARD
    stall = 1'b1;
    iresp_data_ok = 1'b0;
    repeat (4) step();
    check("slow_state", 64'(state_dbg), 64'(WAIT));
    check("slow_hold_pc", dataF.pc, PC0 + 64'h8);
    check("slow_addr", ireq_addr, PC0 + 64'hC);
    stall   = 1'b0;
    is_jump = 1'b1;
    offset  = 64'h100 - 64'h8;
    step();
    check("dis_state", 64'(state_dbg), 64'(DISCARD));
    check("dis_valid", 64'(ireq_valid), 64'd1);
    check("dis_addr", ireq_addr, PC0 + 64'hC);
    check("dis_bubble", 64'(dataF.is_bubble), 64'd1);
    is_jump = 1'b0;
    step();
    check("dis2_addr", ireq_addr, PC0 + 64'hC);
    iresp_data_ok = 1'b1;
    step();
    check("dis_done_state", 64'(state_dbg), 64'(WAIT));
    check("dis_done_addr", ireq_addr, PC0 + 64'h100);
    check("dis_drop_bubble", 64'(dataF.is_bubble), 64'd1);
    step();
    check("dis_tgt_pc", dataF.pc, PC0 + 64'h100);

    // execute redirect beats a simultaneous decode jump, even under stall
    set_inputs(1'b1, 1'b1, 1'b1, 64'h40, 1'b1, PC0 + 64'h200);
    step();
    check("pri_addr", ireq_addr, PC0 + 64'h200);
    check("pri_bubble", 64'(dataF.is_bubble), 64'd1);
    set_inputs(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    step();
    check("pri_tgt_pc", dataF.pc, PC0 + 64'h200);

    // asynchronous reset in the middle of a request
    iresp_data_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("ar_valid", 64'(ireq_valid), 64'd0);
    check("ar_addr", ireq_addr, PC0);
    check("ar_bubble", 64'(dataF.is_bubble), 64'd1);
    check("ar_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk);
    iresp_data_ok = 1'b1;
    step();
    check("ar_hold_valid", 64'(ireq_valid), 64'd0);
    resetn = 1'b1;
    step();
    check("ar_late_bubble", 64'(dataF.is_bubble), 64'd1);
    check("ar_late_addr", ireq_addr, PC0);
    step();
    check("ar_first_pc", dataF.pc, PC0);
    check("ar_first_raw", 64'(dataF.raw_instr), 64'(mem_word(PC0)));

    // randomized run against the program-order stream model
    set_inputs(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    do_reset();
    exp_q.delete();
    exp_q.push_back(PC0);
    for (int i = 0; i < 3000; i++) begin
      iresp_data_ok = ($urandom_range(0, 99) < 50);
      stall         = ($urandom_range(0, 99) < 25);
      is_jump       = ($urandom_range(0, 99) < 15);
      offset        = 64'($urandom_range(0, 127)) * 64'd4 - 64'd256;
      ex_redirect   = ($urandom_range(0, 99) < 5);
      ex_target     = PC0 + 64'($urandom_range(0, 1023)) * 64'd4;
      pre       = dataF;
      pre_valid = ireq_valid;
      pre_addr  = ireq_addr;
      take      = !pre.is_bubble && !stall;
      if (take) begin
        check("rnd_pc", pre.pc, exp_q[0]);
        check("rnd_raw", 64'(pre.raw_instr), 64'(mem_word(pre.pc)));
        accepted++;
      end
      step();
      if (stall && !ex_redirect) begin
        check("rnd_hold_pc", dataF.pc, pre.pc);
        check("rnd_hold_raw", 64'(dataF.raw_instr), 64'(pre.raw_instr));
        check("rnd_hold_bub", 64'(dataF.is_bubble), 64'(pre.is_bubble));
      end
      if (ex_redirect || (is_jump && take)) begin
        check("rnd_redir_bub", 64'(dataF.is_bubble), 64'd1);
      end
      if (pre_valid && !iresp_data_ok) begin
        check("rnd_bus_valid", 64'(ireq_valid), 64'd1);
        check("rnd_bus_addr", ireq_addr, pre_addr);
      end
      if (ex_redirect) begin
        exp_q.delete();
        exp_q.push_back(ex_target);
      end else if (take) begin
        nxt = is_jump ? (pre.pc + offset) : (pre.pc + 64'd4);
        void'(exp_q.pop_front());
        exp_q.push_back(nxt);
      end
    end
    checks++;
    assert (accepted >= 100) else begin
      errors++;
      $error("FAIL rnd_progress observed=%0d expected>=100", accepted);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
